// File: rtl/mem_lsu_if.sv
// Data-SRAM request/response channel between the LSU and memory.
// The master drives the request; the slave answers with addr_ok/data_ok.
interface mem_lsu_if;
  logic        data_req_o;
  logic        data_wr_o;
  logic [3:0]  data_wstrb_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_addr_ok_i;
  logic        data_data_ok_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_wr_o, data_wstrb_o,
    output data_addr_o, data_wdata_o,
    input  data_addr_ok_i, data_data_ok_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_wr_o, data_wstrb_o,
    input  data_addr_o, data_wdata_o,
    output data_addr_ok_i, data_data_ok_i, data_rdata_i
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: IDLE -> REQ -> WAIT handshake to data SRAM.
// Optional LSU_ALIGN_CHECK_EN raises ALE (6'h09) on misaligned H/W access.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  mem_lsu_if.master   bus,
  output logic        valid_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic        excp_o,
  output logic [5:0]  excp_num_o
);

  localparam logic [7:0] EXE_LD_B_OP  = 8'h20;
  localparam logic [7:0] EXE_LD_H_OP  = 8'h21;
  localparam logic [7:0] EXE_LD_W_OP  = 8'h22;
  localparam logic [7:0] EXE_LD_BU_OP = 8'h23;
  localparam logic [7:0] EXE_LD_HU_OP = 8'h24;
  localparam logic [7:0] EXE_ST_B_OP  = 8'h28;
  localparam logic [7:0] EXE_ST_H_OP  = 8'h29;
  localparam logic [7:0] EXE_ST_W_OP  = 8'h2A;
  localparam logic [5:0] EXC_ALE      = 6'h09;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_nxt;
  logic        is_ld, is_st, is_mem, is_h, is_w;
  logic        misalign, accept, done;
  logic [7:0]  op_q;
  logic [1:0]  off_q;
  logic [4:0]  wd_q;
  logic        wreg_q;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_data;

  // Classify the incoming operation by kind and access size.
  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    is_h  = 1'b0;
    is_w  = 1'b0;
    case (aluop_i)
      EXE_LD_B_OP, EXE_LD_BU_OP: is_ld = 1'b1;
      EXE_LD_H_OP, EXE_LD_HU_OP: begin is_ld = 1'b1; is_h = 1'b1; end
      EXE_LD_W_OP: begin is_ld = 1'b1; is_w = 1'b1; end
      EXE_ST_B_OP: is_st = 1'b1;
      EXE_ST_H_OP: begin is_st = 1'b1; is_h = 1'b1; end
      EXE_ST_W_OP: begin is_st = 1'b1; is_w = 1'b1; end
      default: ;
    endcase
  end

  assign is_mem = is_ld | is_st;

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign = is_mem &&
    ((is_h && mem_addr_i[0]) || (is_w && mem_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign accept = (state == IDLE) && valid_i && is_mem && !misalign;

  // Byte-lane strobe and replicated write data for stores.
  always_comb begin
    st_strb  = 4'b0000;
    st_wdata = 32'h0;
    case (aluop_i)
      EXE_ST_B_OP: begin
        st_strb  = 4'b0001 << mem_addr_i[1:0];
        st_wdata = {4{reg2_i[7:0]}};
      end
      EXE_ST_H_OP: begin
        st_strb  = 4'b0011 << mem_addr_i[1:0];
        st_wdata = {2{reg2_i[15:0]}};
      end
      EXE_ST_W_OP: begin
        st_strb  = 4'b1111;
        st_wdata = reg2_i;
      end
      default: ;
    endcase
  end

  // Select and extend the loaded byte/half from the returned word.
  always_comb begin
    ld_data = 32'h0;
    ld_h    = off_q[1] ? bus.data_rdata_i[31:16] : bus.data_rdata_i[15:0];
    unique case (off_q)
      2'd0: ld_b = bus.data_rdata_i[7:0];
      2'd1: ld_b = bus.data_rdata_i[15:8];
      2'd2: ld_b = bus.data_rdata_i[23:16];
      default: ld_b = bus.data_rdata_i[31:24];
    endcase
    case (op_q)
      EXE_LD_B_OP:  ld_data = {{24{ld_b[7]}}, ld_b};
      EXE_LD_BU_OP: ld_data = {24'h0, ld_b};
      EXE_LD_H_OP:  ld_data = {{16{ld_h[15]}}, ld_h};
      EXE_LD_HU_OP: ld_data = {16'h0, ld_h};
      EXE_LD_W_OP:  ld_data = bus.data_rdata_i;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, completion and stall; stall drops in the completing cycle.
  always_comb begin
    state_nxt  = state;
    stallreq_o = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt  = REQ;
          stallreq_o = 1'b1;
        end
      end
      REQ: begin
        if (bus.data_addr_ok_i && bus.data_data_ok_i) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end else begin
          stallreq_o = 1'b1;
          if (bus.data_addr_ok_i) state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.data_data_ok_i) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end else begin
          stallreq_o = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latching, bus drive and the registered WB-side result.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o          <= 1'b0;
      wd_o             <= 5'h0;
      wreg_o           <= 1'b0;
      wdata_o          <= 32'h0;
      excp_o           <= 1'b0;
      excp_num_o       <= 6'h0;
      bus.data_req_o   <= 1'b0;
      bus.data_wr_o    <= 1'b0;
      bus.data_wstrb_o <= 4'h0;
      bus.data_addr_o  <= 32'h0;
      bus.data_wdata_o <= 32'h0;
      op_q             <= 8'h0;
      off_q            <= 2'b00;
      wd_q             <= 5'h0;
      wreg_q           <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      excp_o     <= 1'b0;
      excp_num_o <= 6'h0;
      if (state == IDLE && valid_i) begin
        if (misalign) begin
          valid_o    <= 1'b1;
          excp_o     <= 1'b1;
          excp_num_o <= EXC_ALE;
          wd_o       <= wd_i;
          wreg_o     <= 1'b0;
          wdata_o    <= mem_addr_i;
        end else if (is_mem) begin
          op_q             <= aluop_i;
          off_q            <= mem_addr_i[1:0];
          wd_q             <= wd_i;
          wreg_q           <= wreg_i & is_ld;
          bus.data_req_o   <= 1'b1;
          bus.data_wr_o    <= is_st;
          bus.data_wstrb_o <= st_strb;
          bus.data_addr_o  <= {mem_addr_i[31:2], 2'b00};
          bus.data_wdata_o <= st_wdata;
        end else begin
          valid_o <= 1'b1;
          wd_o    <= wd_i;
          wreg_o  <= wreg_i;
          wdata_o <= wdata_i;
        end
      end
      if (state == REQ && bus.data_addr_ok_i) bus.data_req_o <= 1'b0;
      if (done) begin
        valid_o <= 1'b1;
        wd_o    <= wd_q;
        wreg_o  <= wreg_q;
        wdata_o <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: vector table, corner sequences and
// randomized loads/stores against a spec-level reference model.
module tb_mem_lsu;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] LD_B   = 8'h20;
  localparam logic [7:0] LD_H   = 8'h21;
  localparam logic [7:0] LD_W   = 8'h22;
  localparam logic [7:0] LD_BU  = 8'h23;
  localparam logic [7:0] LD_HU  = 8'h24;
  localparam logic [7:0] ST_B   = 8'h28;
  localparam logic [7:0] ST_H   = 8'h29;
  localparam logic [7:0] ST_W   = 8'h2A;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        valid_o, wreg_o, stallreq_o, excp_o;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o;
  logic [5:0]  excp_num_o;

  mem_lsu_if bus ();

  mem_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .aluop_i    (aluop_i),
    .mem_addr_i (mem_addr_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wdata_i    (wdata_i),
    .bus        (bus),
    .valid_o    (valid_o),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .stallreq_o (stallreq_o),
    .excp_o     (excp_o),
    .excp_num_o (excp_num_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall_issue, stall_done, stable;
    logic        req, wr, valid, valid_after, wreg, excp;
    logic [3:0]  strb;
    logic [4:0]  wd;
    logic [31:0] baddr, bwdata, wdata;
  } res_t;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr, reg2, rdata;
    logic [3:0]  strb;
    logic [31:0] bw, res;
  } vec_t;

  function automatic bit is_store(input logic [7:0] op);
    return op == ST_B || op == ST_H || op == ST_W;
  endfunction

  // Reference behaviour written from the byte-lane rules with arithmetic.
  function automatic void model(input logic [7:0] op,
      input logic [31:0] addr, reg2, rdata,
      output logic [3:0] strb, output logic [31:0] bw,
      output logic [31:0] res);
    int unsigned v;
    strb = 4'h0;
    bw   = 32'h0;
    res  = 32'h0;
    case (op)
      ST_B: begin
        strb = 4'((1 << addr[1:0]) & 15);
        bw   = (reg2 & 32'hFF) * 32'h0101_0101;
      end
      ST_H: begin
        strb = 4'((3 << addr[1:0]) & 15);
        bw   = (reg2 & 32'hFFFF) * 32'h0001_0001;
      end
      ST_W: begin
        strb = 4'hF;
        bw   = reg2;
      end
      LD_B, LD_BU: begin
        v = (rdata >> (8 * addr[1:0])) & 32'hFF;
        if (op == LD_B && v >= 128) v = v - 256;
        res = v;
      end
      LD_H, LD_HU: begin
        v = (rdata >> (16 * addr[1])) & 32'hFFFF;
        if (op == LD_H && v >= 32768) v = v - 65536;
        res = v;
      end
      LD_W: res = rdata;
      default: ;
    endcase
  endfunction

  function automatic bit fields_ok(input res_t r);
    return bus.data_req_o === 1'b1 && bus.data_wr_o === r.wr &&
           bus.data_wstrb_o === r.strb && bus.data_addr_o === r.baddr &&
           bus.data_wdata_o === r.bwdata && valid_o === 1'b0;
  endfunction

  // Drive one memory access; the responder waits adly cycles for addr_ok
  // and ddly further cycles for data_ok (0 = same cycle as addr_ok).
  task automatic run_mem(input logic [7:0] op, input logic [31:0] addr,
      input logic [31:0] reg2, rdata, input logic [4:0] wd,
      input logic wreg, input int adly, input int ddly, input bit noise,
      output res_t r);
    r = '{default: '0};
    r.stable = 1'b1;
    @(negedge clk);
    valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
    wd_i = wd; wreg_i = wreg; wdata_i = 32'hDEAD_0000;
    #1 r.stall_issue = stallreq_o;
    @(negedge clk);
    valid_i = noise;
    if (noise) begin
      aluop_i = OP_ADD; mem_addr_i = $urandom; reg2_i = $urandom;
    end
    r.req = bus.data_req_o; r.wr = bus.data_wr_o;
    r.strb = bus.data_wstrb_o; r.baddr = bus.data_addr_o;
    r.bwdata = bus.data_wdata_o;
    for (int i = 0; i < adly; i++) begin
      bus.data_data_ok_i = noise && (i == 0);
      bus.data_rdata_i = $urandom;
      #1 if (!fields_ok(r) || stallreq_o !== 1'b1) r.stable = 1'b0;
      @(negedge clk);
    end
    if (!fields_ok(r)) r.stable = 1'b0;
    bus.data_addr_ok_i = 1'b1;
    bus.data_data_ok_i = (ddly == 0);
    bus.data_rdata_i = (ddly == 0) ? rdata : $urandom;
    #1 r.stall_done = stallreq_o;
    @(negedge clk);
    bus.data_addr_ok_i = 1'b0;
    bus.data_data_ok_i = 1'b0;
    if (ddly > 0) begin
      for (int i = 1; i < ddly; i++) begin
        if (bus.data_req_o !== 1'b0 || valid_o !== 1'b0 ||
            stallreq_o !== 1'b1) r.stable = 1'b0;
        @(negedge clk);
      end
      if (bus.data_req_o !== 1'b0) r.stable = 1'b0;
      bus.data_data_ok_i = 1'b1;
      bus.data_rdata_i = rdata;
      #1 r.stall_done = stallreq_o;
      @(negedge clk);
      bus.data_data_ok_i = 1'b0;
    end
    valid_i = 1'b0;
    r.valid = valid_o; r.wd = wd_o; r.wreg = wreg_o;
    r.wdata = wdata_o; r.excp = excp_o;
    @(negedge clk);
    r.valid_after = valid_o;
  endtask

  task automatic check_mem(input string n, input logic [7:0] op,
      input logic [31:0] addr, reg2, rdata, input logic [4:0] wd,
      input logic wreg, input res_t r);
    logic [3:0]  strb;
    logic [31:0] bw, res;
    bit st;
    st = is_store(op);
    model(op, addr, reg2, rdata, strb, bw, res);
    chk({n, ".stall_issue"}, r.stall_issue, 1);
    chk({n, ".req"}, r.req, 1);
    chk({n, ".wr"}, r.wr, st);
    chk({n, ".strb"}, r.strb, strb);
    chk({n, ".addr"}, r.baddr, {addr[31:2], 2'b00});
    if (st) chk({n, ".bus_wdata"}, r.bwdata, bw);
    chk({n, ".stable"}, r.stable, 1);
    chk({n, ".stall_done"}, r.stall_done, 0);
    chk({n, ".valid"}, r.valid, 1);
    chk({n, ".wd"}, r.wd, wd);
    chk({n, ".wreg"}, r.wreg, wreg && !st);
    if (!st) chk({n, ".wdata"}, r.wdata, res);
    chk({n, ".excp"}, r.excp, 0);
    chk({n, ".valid_once"}, r.valid_after, 0);
  endtask

  task automatic run_alu(input string n, input logic [4:0] wd,
      input logic wreg, input logic [31:0] d);
    @(negedge clk);
    valid_i = 1'b1; aluop_i = OP_ADD; wd_i = wd; wreg_i = wreg;
    wdata_i = d; mem_addr_i = $urandom;
    #1 chk({n, ".stall"}, stallreq_o, 0);
    @(negedge clk);
    valid_i = 1'b0;
    chk({n, ".valid"}, valid_o, 1);
    chk({n, ".res"}, {wd_o, wreg_o, wdata_o[25:0]}, {wd, wreg, d[25:0]});
    chk({n, ".wdata"}, wdata_o, d);
    chk({n, ".no_req"}, bus.data_req_o, 0);
  endtask

  vec_t tbl[9];
  res_t r;
  logic [7:0] mem_ops[8] = '{LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W};

  initial begin
    rst = 1'b1; valid_i = 1'b0; aluop_i = 8'h0; mem_addr_i = 32'h0;
    reg2_i = 32'h0; wd_i = 5'h0; wreg_i = 1'b0; wdata_i = 32'h0;
    bus.data_addr_ok_i = 1'b0; bus.data_data_ok_i = 1'b0;
    bus.data_rdata_i = 32'h0;

    tbl[0] = '{LD_B,  32'h1003, 32'h0, 32'h80FF_FFFF, 4'h0, 32'h0, 32'hFFFF_FF80};
    tbl[1] = '{LD_BU, 32'h1003, 32'h0, 32'h80FF_FFFF, 4'h0, 32'h0, 32'h0000_0080};
    tbl[2] = '{ST_H,  32'h2002, 32'h1234_ABCD, 32'h0, 4'hC, 32'hABCD_ABCD, 32'h0};
    tbl[3] = '{ST_B,  32'h4001, 32'h0000_00A5, 32'h0, 4'h2, 32'hA5A5_A5A5, 32'h0};
    tbl[4] = '{ST_W,  32'h5000, 32'h0BAD_F00D, 32'h0, 4'hF, 32'h0BAD_F00D, 32'h0};
    tbl[5] = '{LD_H,  32'h6002, 32'h0, 32'h8001_1234, 4'h0, 32'h0, 32'hFFFF_8001};
    tbl[6] = '{LD_HU, 32'h6000, 32'h0, 32'h8001_F234, 4'h0, 32'h0, 32'h0000_F234};
    tbl[7] = '{LD_W,  32'h7004, 32'h0, 32'hCAFE_BABE, 4'h0, 32'h0, 32'hCAFE_BABE};
    tbl[8] = '{LD_B,  32'h1001, 32'h0, 32'h1234_5678, 4'h0, 32'h0, 32'h0000_0056};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.valid", valid_o, 0);
    chk("rst.wb", {wd_o, wreg_o}, 0);
    chk("rst.wdata", wdata_o, 0);
    chk("rst.excp", {excp_o, excp_num_o}, 0);
    chk("rst.req", {bus.data_req_o, bus.data_wr_o, bus.data_wstrb_o}, 0);
    chk("rst.addr", bus.data_addr_o, 0);
    chk("rst.bwdata", bus.data_wdata_o, 0);
    chk("rst.stall", stallreq_o, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_mem(tbl[i].op, tbl[i].addr, tbl[i].reg2, tbl[i].rdata,
              5'(i + 1), 1'b1, 0, i % 3, 1'b0, r);
      chk($sformatf("vec%0d.strb", i), r.strb, tbl[i].strb);
      chk($sformatf("vec%0d.addr", i), r.baddr, {tbl[i].addr[31:2], 2'b00});
      if (is_store(tbl[i].op))
        chk($sformatf("vec%0d.bwdata", i), r.bwdata, tbl[i].bw);
      else
        chk($sformatf("vec%0d.wdata", i), r.wdata, tbl[i].res);
      chk($sformatf("vec%0d.wreg", i), r.wreg, !is_store(tbl[i].op));
      chk($sformatf("vec%0d.valid", i), {r.valid, r.valid_after}, 2'b10);
    end

    // addr_ok held off 3 cycles with noise on valid_i and data_ok
    run_mem(LD_HU, 32'h9006, 32'h0, 32'hBEEF_0000, 5'd7, 1'b1, 3, 2, 1'b1, r);
    check_mem("delay3", LD_HU, 32'h9006, 32'h0, 32'hBEEF_0000, 5'd7, 1'b1, r);
    // addr_ok and data_ok in the same cycle
    run_mem(ST_W, 32'hA000, 32'h5555_AAAA, 32'h0, 5'd9, 1'b1, 0, 0, 1'b0, r);
    check_mem("same_cycle", ST_W, 32'hA000, 32'h5555_AAAA, 32'h0,
              5'd9, 1'b1, r);

    // ADD then LD_W back to back
    @(negedge clk);
    valid_i = 1'b1; aluop_i = OP_ADD; wd_i = 5'd3; wreg_i = 1'b1;
    wdata_i = 32'd5;
    @(negedge clk);
    chk("b2b.add_valid", valid_o, 1);
    chk("b2b.add_wdata", wdata_o, 5);
    aluop_i = LD_W; mem_addr_i = 32'h0100; wd_i = 5'd4;
    @(negedge clk);
    valid_i = 1'b0;
    chk("b2b.req", bus.data_req_o, 1);
    chk("b2b.gap", valid_o, 0);
    bus.data_addr_ok_i = 1'b1; bus.data_data_ok_i = 1'b1;
    bus.data_rdata_i = 32'h0000_CAFE;
    @(negedge clk);
    bus.data_addr_ok_i = 1'b0; bus.data_data_ok_i = 1'b0;
    chk("b2b.ld_valid", valid_o, 1);
    chk("b2b.ld_wdata", wdata_o, 32'h0000_CAFE);
    chk("b2b.ld_wd", wd_o, 4);

    // reset while waiting for data_ok
    @(negedge clk);
    valid_i = 1'b1; aluop_i = LD_W; mem_addr_i = 32'h8000; wreg_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; bus.data_addr_ok_i = 1'b1;
    @(negedge clk);
    bus.data_addr_ok_i = 1'b0;
    chk("rstw.in_wait", stallreq_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw.req", bus.data_req_o, 0);
    chk("rstw.valid", valid_o, 0);
    chk("rstw.stall", stallreq_o, 0);
    bus.data_data_ok_i = 1'b1; bus.data_rdata_i = 32'h1111_2222;
    @(negedge clk);
    bus.data_data_ok_i = 1'b0;
    chk("rstw.late_ok", valid_o, 0);
    @(negedge clk);
    chk("rstw.late_ok2", valid_o, 0);

    // misaligned word load
`ifdef LSU_ALIGN_CHECK_EN
    @(negedge clk);
    valid_i = 1'b1; aluop_i = LD_W; mem_addr_i = 32'h3002; wreg_i = 1'b1;
    #1 chk("ale.stall", stallreq_o, 0);
    @(negedge clk);
    valid_i = 1'b0;
    chk("ale.req", bus.data_req_o, 0);
    chk("ale.valid", valid_o, 1);
    chk("ale.excp", excp_o, 1);
    chk("ale.num", excp_num_o, 6'h09);
    chk("ale.wreg", wreg_o, 0);
    @(negedge clk);
    chk("ale.once", {valid_o, excp_o, bus.data_req_o}, 0);
`else
    run_mem(LD_W, 32'h3002, 32'h0, 32'h1122_3344, 5'd2, 1'b1, 1, 1, 1'b0, r);
    check_mem("unaligned_w", LD_W, 32'h3002, 32'h0, 32'h1122_3344,
              5'd2, 1'b1, r);
`endif

    // randomized mix against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  op;
      logic [31:0] addr, reg2, rdata;
      logic [4:0]  wd;
      logic        wreg;
      op = mem_ops[$urandom_range(0, 7)];
      addr = $urandom; reg2 = $urandom; rdata = $urandom;
      wd = 5'($urandom); wreg = 1'($urandom);
`ifdef LSU_ALIGN_CHECK_EN
      if (op == LD_H || op == LD_HU || op == ST_H) addr[0] = 1'b0;
      if (op == LD_W || op == ST_W) addr[1:0] = 2'b00;
`endif
      if ($urandom_range(0, 2) == 0) begin
        run_alu($sformatf("rnd%0d.alu", n), wd, wreg, rdata);
      end else begin
        run_mem(op, addr, reg2, rdata, wd, wreg, $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom), r);
        check_mem($sformatf("rnd%0d", n), op, addr, reg2, rdata,
                  wd, wreg, r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have rst  input  1  reset, synchronous, active-high (`RstEnable` level).
REQ-003 SHALL have valid_i  input  1  EX-stage instruction valid this cycle.
REQ-004 SHALL have aluop_i  input  8  operation code (`AluOpBus`, `EXE_*_OP` encodings).
REQ-005 SHALL have mem_addr_i  input  32  effective address (base + sign-extended si12).
REQ-006 SHALL have reg2_i  input  32  store source data.
REQ-007 SHALL have wd_i / wreg_i / wdata_i  input  5/1/32  destination, write-enable, non-memory result.
REQ-008 SHALL have data_req_o, data_wr_o, data_wstrb_o, data_addr_o, data_wdata_o  output  1/1/4/32/32  data-SRAM request channel.
REQ-009 SHALL have data_addr_ok_i, data_data_ok_i, data_rdata_i  input  1/1/32  SRAM address accept, data return, load data.
REQ-010 SHALL have valid_o, wd_o, wreg_o, wdata_o  output  1/5/1/32  registered WB-side result.
REQ-011 SHALL have stallreq_o  output  1  holds EX/upstream while access outstanding.
REQ-012 SHALL have excp_o, excp_num_o  output  1/6  address-alignment exception flag and code (ALE = 6'h09).

Function
REQ-013 SHALL implement FSM IDLE -> REQ -> WAIT -> IDLE.
REQ-014 SHALL, in IDLE with valid_i and non-memory aluop, register wd/wreg/wdata to outputs next cycle, valid_o=1, no bus activity, stallreq_o=0.
REQ-015 SHALL, in IDLE with valid_i and EXE_LD_{B,H,W,BU,HU}_OP or EXE_ST_{B,H,W}_OP, latch op/addr/data/wd/wreg, enter REQ, assert stallreq_o combinationally same cycle.
REQ-016 SHALL hold data_req_o=1 and all request fields stable in REQ until data_addr_ok_i=1; then enter WAIT.
REQ-017 SHALL drive data_addr_o = {addr[31:2],2'b00}; data_wr_o=1 for stores only.
REQ-018 SHALL form store strobe: ST_B 4'b0001<<addr[1:0], ST_H 4'b0011<<addr[1:0], ST_W 4'b1111; loads 4'b0000.
REQ-019 SHALL replicate store data: ST_B {4{reg2[7:0]}}, ST_H {2{reg2[15:0]}}, ST_W reg2.
REQ-020 SHALL, in WAIT on data_data_ok_i=1, return to IDLE and present result next cycle with valid_o=1, stallreq_o dropping in the data_ok cycle.
REQ-021 SHALL treat data_addr_ok_i and data_data_ok_i both high in REQ as complete (REQ -> IDLE directly).
REQ-022 SHALL extract load byte/half by addr[1:0]/addr[1]; LD_B/LD_H sign-extend, LD_BU/LD_HU zero-extend, LD_W whole word.
REQ-023 SHALL force wreg_o=0 for stores; wreg_o=latched wreg_i for loads.
REQ-024 SHALL ignore valid_i while not IDLE, and ignore data_data_ok_i while IDLE or REQ-without-addr_ok.
REQ-025 SHALL keep valid_o high exactly one cycle per retired instruction.
REQ-026 SHALL give load-to-result latency of 3 cycles minimum (issue, addr_ok+data_ok, register).

Reset
REQ-027 SHALL, on rst=1 at a rising edge, enter IDLE and clear valid_o, wreg_o, wd_o, wdata_o, excp_o, excp_num_o, data_req_o, data_wr_o, data_wstrb_o, data_addr_o, data_wdata_o to 0.
REQ-028 SHALL abandon any in-flight access on rst; data_data_ok_i arriving afterwards SHALL be ignored.

Configuration
REQ-029 SHALL, with LSU_ALIGN_CHECK_EN defined, flag misaligned accesses (H with addr[0]=1, W with addr[1:0]!=0) in IDLE: no bus request, next-cycle valid_o=1, excp_o=1, excp_num_o=6'h09, wreg_o=0.
REQ-030 SHALL, without LSU_ALIGN_CHECK_EN, omit the check, hold excp_o=0, and issue misaligned accesses using addr[1:0] as given.

Verification
REQ-031 SHALL cover: rst mid-WAIT -> next cycle data_req_o=0, valid_o=0; later data_ok produces no valid_o.
REQ-032 SHALL cover: LD_B addr=0x1003, rdata=0x80FF_FFFF -> wdata_o=0xFFFF_FF80; LD_BU same -> 0x0000_0080.
REQ-033 SHALL cover: ST_H addr=0x2002, reg2=0x1234_ABCD -> wstrb=4'b1100, wdata=0xABCD_ABCD, addr_o=0x2000, wreg_o=0.
REQ-034 SHALL cover: addr_ok delayed 3 cycles -> request fields stable, stallreq_o=1 throughout; addr_ok+data_ok same cycle -> completion, valid_o next cycle.
REQ-035 SHALL cover: LD_W addr=0x3002 with LSU_ALIGN_CHECK_EN -> no data_req_o, excp_o=1, excp_num_o=6'h09.
REQ-036 SHALL cover: back-to-back ADD (wdata_i=5) then LD_W -> valid_o on consecutive retirements, ADD result 5 one cycle after issue.
